proc_ctrl: RTL and testbench

PROC_CTRL -- requirements
Module: proc_ctrl

---
 rtl/proc_pkg.sv | 50 +++++
 rtl/proc_acc.sv | 28 ++
 rtl/proc_ctrl.sv | 131 +++++++++++++
 tb/tb_proc_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the iteration controller and its accumulator.
package proc_pkg;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned STATUS_W   = 4;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned WDOG_W     = 10;
  localparam int unsigned WDOG_LIMIT = 1023;

  localparam logic [CMD_W-1:0] CMD_NOP   = 4'd0;
  localparam logic [CMD_W-1:0] CMD_START = 4'd1;
  localparam logic [CMD_W-1:0] CMD_ABORT = 4'd2;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 4'd3;

  localparam logic [STATUS_W-1:0] STAT_IDLE    = 4'd0;
  localparam logic [STATUS_W-1:0] STAT_BUSY    = 4'd1;
  localparam logic [STATUS_W-1:0] STAT_DONE    = 4'd2;
  localparam logic [STATUS_W-1:0] STAT_ABORTED = 4'd3;
  localparam logic [STATUS_W-1:0] STAT_TIMEOUT = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_REQ     = 3'd2,
    S_ACC     = 3'd3,
    S_DONE    = 3'd4,
    S_ABORTED = 3'd5,
    S_TIMEOUT = 3'd6
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] sq;
  } dp_sample_t;

  // Host-visible status code for a controller state.
  function automatic logic [STATUS_W-1:0] status_of(input state_t s);
    logic [STATUS_W-1:0] st;
    case (s)
      S_LOAD, S_REQ, S_ACC: st = STAT_BUSY;
      S_DONE:               st = STAT_DONE;
      S_ABORTED:            st = STAT_ABORTED;
      S_TIMEOUT:            st = STAT_TIMEOUT;
      default:              st = STAT_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/proc_acc.sv
// Dual 64-bit wrapping accumulator: sum of samples and sum of squared samples.
module proc_acc
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              nRESET,
  input  logic              clr,
  input  logic              add_en,
  input  dp_sample_t        sample,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] pow_sum
);

  // Clear has priority; additions wrap modulo 2^64.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sum     <= '0;
      pow_sum <= '0;
    end else if (clr) begin
      sum     <= '0;
      pow_sum <= '0;
    end else if (add_en) begin
      sum     <= sum + sample.val;
      pow_sum <= pow_sum + sample.sq;
    end
  end

endmodule

// File: rtl/proc_ctrl.sv
// Iteration controller: requests datapath samples niter times and accumulates
// them, with host START/ABORT/CLEAR commands and a per-request watchdog.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic                clk,
  input  logic                nRESET,
  input  logic [CMD_W-1:0]    proc_cmd,
  input  logic [CNT_W-1:0]    niter,
  output logic                dp_req,
  input  logic                dp_ack,
  input  logic [DATA_W-1:0]   dp_val,
  input  logic [DATA_W-1:0]   dp_sq,
  output logic [STATUS_W-1:0] proc_status,
  output logic [DATA_W-1:0]   proc_sum_dout,
  output logic [DATA_W-1:0]   proc_pow_sum_dout
);

  state_t            state, state_nx;
  logic [CMD_W-1:0]  cmd_q, cmd_prev;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [WDOG_W-1:0] wdog, wdog_nx;
  logic              cmd_new, do_start, do_abort, do_clear;
  logic              acc_clr, acc_add;
  dp_sample_t        sample;

  // Host command is a level; sample it and act only on a change to non-zero.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cmd_q    <= '0;
      cmd_prev <= '0;
    end else begin
      cmd_q    <= proc_cmd;
      cmd_prev <= cmd_q;
    end
  end

  assign cmd_new  = (cmd_q != CMD_NOP) && (cmd_q != cmd_prev);
  assign do_start = cmd_new && (cmd_q == CMD_START);
  assign do_abort = cmd_new && (cmd_q == CMD_ABORT);
  assign do_clear = cmd_new && (cmd_q == CMD_CLEAR);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wdog_nx  = wdog;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ABORTED, S_TIMEOUT: begin
        if (do_start) begin
          state_nx = S_LOAD;
        end else if (do_clear) begin
          acc_clr  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (do_abort) begin
          state_nx = S_ABORTED;
        end else begin
          acc_clr  = 1'b1;
          cnt_nx   = niter;
          wdog_nx  = '0;
          state_nx = (niter == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // Abort wins over a coincident acknowledge, which is then dropped.
        if (do_abort) begin
          state_nx = S_ABORTED;
        end else if (dp_ack) begin
          acc_add  = 1'b1;
          cnt_nx   = cnt - CNT_W'(1);
          wdog_nx  = wdog + WDOG_W'(1);
          state_nx = S_ACC;
        end else if (wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
          wdog_nx  = wdog + WDOG_W'(1);
          state_nx = S_TIMEOUT;
        end else begin
          wdog_nx  = wdog + WDOG_W'(1);
        end
      end
      S_ACC: begin
        if (do_abort) begin
          state_nx = S_ABORTED;
        end else if (cnt == '0) begin
          state_nx = S_DONE;
        end else begin
          wdog_nx  = '0;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters and registered outputs follow the next state so status and
  // request change on the same edge as the state.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cnt         <= '0;
      wdog        <= '0;
      dp_req      <= 1'b0;
      proc_status <= STAT_IDLE;
    end else begin
      cnt         <= cnt_nx;
      wdog        <= wdog_nx;
      dp_req      <= (state_nx == S_REQ);
      proc_status <= status_of(state_nx);
    end
  end

  assign sample = '{val: dp_val, sq: dp_sq};

  proc_acc u_acc (
    .clk     (clk),
    .nRESET  (nRESET),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .sample  (sample),
    .sum     (proc_sum_dout),
    .pow_sum (proc_pow_sum_dout)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl with a result scoreboard and a dp_req pulse monitor.
module tb_proc_ctrl;

  logic        clk;
  logic        nRESET;
  logic [3:0]  proc_cmd;
  logic [31:0] niter;
  logic        dp_req;
  logic        dp_ack;
  logic [63:0] dp_val;
  logic [63:0] dp_sq;
  logic [3:0]  proc_status;
  logic [63:0] proc_sum_dout;
  logic [63:0] proc_pow_sum_dout;

  typedef struct {
    logic [3:0]  st;
    logic [63:0] sum;
    logic [63:0] pow;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   req_pulses = 0;
  logic req_d = 1'b0;
  int   p0;
  int   n;

  proc_ctrl dut (
    .clk               (clk),
    .nRESET            (nRESET),
    .proc_cmd          (proc_cmd),
    .niter             (niter),
    .dp_req            (dp_req),
    .dp_ack            (dp_ack),
    .dp_val            (dp_val),
    .dp_sq             (dp_sq),
    .proc_status       (proc_status),
    .proc_sum_dout     (proc_sum_dout),
    .proc_pow_sum_dout (proc_pow_sum_dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    req_d <= dp_req;
    if (dp_req && !req_d) req_pulses <= req_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_cmd(input logic [3:0] c);
    proc_cmd = c;
    step();
    proc_cmd = 4'd0;
  endtask

  task automatic wait_req(input string tag);
    int i = 0;
    while (dp_req !== 1'b1 && i < 50) begin
      step();
      i++;
    end
    check({tag, "_req_seen"}, 64'(dp_req), 64'd1);
  endtask

  task automatic wait_status(input string tag, input logic [3:0] st, input int budget);
    int i = 0;
    while (proc_status !== st && i < budget) begin
      step();
      i++;
    end
    check({tag, "_status_reached"}, 64'(proc_status), 64'(st));
  endtask

  // Datapath model: answer the pending request after d cycles with one sample.
  task automatic serve(input string tag, input logic [63:0] v, input logic [63:0] s, input int d);
    wait_req(tag);
    repeat (d) step();
    dp_ack = 1'b1;
    dp_val = v;
    dp_sq  = s;
    step();
    dp_ack = 1'b0;
    dp_val = 64'd0;
    dp_sq  = 64'd0;
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb_empty: observed=0 expected=1 entries", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_status"},  64'(proc_status),  64'(e.st));
      check({tag, "_sum"},     proc_sum_dout,     e.sum);
      check({tag, "_pow_sum"}, proc_pow_sum_dout, e.pow);
    end
  endtask

  initial begin
    nRESET = 1'b0; proc_cmd = 4'd0; niter = 32'd0;
    dp_ack = 1'b0; dp_val = 64'd0; dp_sq = 64'd0;
    #5;
    check("reset_dp_req",  64'(dp_req), 64'd0);
    check("reset_status",  64'(proc_status), 64'd0);
    check("reset_sum",     proc_sum_dout, 64'd0);
    check("reset_pow_sum", proc_pow_sum_dout, 64'd0);
    repeat (2) step();
    nRESET = 1'b1;
    step();

    // Three iterations with START latency probe.
    niter = 32'd3;
    p0 = req_pulses;
    sb.push_back('{4'd2, 64'd21, 64'd155});
    pulse_cmd(4'd1);
    check("lat_n0_status", 64'(proc_status), 64'd0);
    step();
    check("lat_n1_status", 64'(proc_status), 64'd1);
    check("lat_n1_req",    64'(dp_req), 64'd0);
    step();
    check("lat_n2_req",    64'(dp_req), 64'd1);
    serve("run3_a", 64'd5, 64'd25, 2);
    check("acc_gap_req", 64'(dp_req), 64'd0);
    serve("run3_b", 64'd7, 64'd49, 2);
    serve("run3_c", 64'd9, 64'd81, 2);
    wait_status("run3", 4'd2, 20);
    expect_result("run3");
    check("run3_pulses", 64'(req_pulses - p0), 64'd3);

    // Zero iterations: DONE two cycles after the accepted edge, no request.
    niter = 32'd0;
    p0 = req_pulses;
    sb.push_back('{4'd2, 64'd0, 64'd0});
    pulse_cmd(4'd1);
    step();
    step();
    expect_result("zero");
    check("zero_pulses", 64'(req_pulses - p0), 64'd0);

    // Wrap-around of the 64-bit sum.
    niter = 32'd2;
    sb.push_back('{4'd2, 64'd1, 64'd8});
    pulse_cmd(4'd1);
    serve("wrap_a", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1);
    serve("wrap_b", 64'd2, 64'd5, 0);
    wait_status("wrap", 4'd2, 20);
    expect_result("wrap");

    // ABORT coinciding with the third acknowledge.
    niter = 32'd5;
    p0 = req_pulses;
    sb.push_back('{4'd3, 64'd30, 64'd500});
    pulse_cmd(4'd1);
    serve("abort_a", 64'd10, 64'd100, 1);
    serve("abort_b", 64'd20, 64'd400, 1);
    wait_req("abort_c");
    proc_cmd = 4'd2;
    step();
    dp_ack = 1'b1; dp_val = 64'd100; dp_sq = 64'd10000; proc_cmd = 4'd0;
    step();
    dp_ack = 1'b0; dp_val = 64'd0; dp_sq = 64'd0;
    check("abort_dp_req", 64'(dp_req), 64'd0);
    expect_result("abort");
    check("abort_pulses", 64'(req_pulses - p0), 64'd3);

    // Acknowledge and ABORT outside an active run are ignored.
    dp_ack = 1'b1; dp_val = 64'd999; dp_sq = 64'd999;
    step();
    dp_ack = 1'b0; dp_val = 64'd0; dp_sq = 64'd0;
    pulse_cmd(4'd2);
    step();
    check("stray_status", 64'(proc_status), 64'd3);
    check("stray_sum",    proc_sum_dout, 64'd30);

    // CLEAR from ABORTED.
    pulse_cmd(4'd3);
    step();
    check("clear1_status",  64'(proc_status), 64'd0);
    check("clear1_sum",     proc_sum_dout, 64'd0);
    check("clear1_pow_sum", proc_pow_sum_dout, 64'd0);

    // Watchdog: no acknowledge ever.
    niter = 32'd1;
    sb.push_back('{4'd4, 64'd0, 64'd0});
    pulse_cmd(4'd1);
    wait_req("tmo");
    n = 0;
    for (int i = 0; i < 1100 && proc_status !== 4'd4; i++) begin
      if (dp_req) n++;
      step();
    end
    check("tmo_req_cycles", 64'(n), 64'd1023);
    check("tmo_dp_req", 64'(dp_req), 64'd0);
    expect_result("tmo");
    pulse_cmd(4'd3);
    step();
    check("clear2_status", 64'(proc_status), 64'd0);
    check("clear2_sum",    proc_sum_dout, 64'd0);

    // Held START level runs once; a 1->0->1 toggle starts again.
    niter = 32'd1;
    p0 = req_pulses;
    sb.push_back('{4'd2, 64'd4, 64'd16});
    proc_cmd = 4'd1;
    serve("held", 64'd4, 64'd16, 0);
    wait_status("held", 4'd2, 10);
    expect_result("held");
    repeat (10) step();
    check("held_no_restart_status", 64'(proc_status), 64'd2);
    check("held_no_restart_pulses", 64'(req_pulses - p0), 64'd1);
    proc_cmd = 4'd0;
    step();
    proc_cmd = 4'd1;
    step();
    sb.push_back('{4'd2, 64'd6, 64'd36});
    serve("rerun", 64'd6, 64'd36, 1);
    wait_status("rerun", 4'd2, 10);
    expect_result("rerun");
    check("rerun_pulses", 64'(req_pulses - p0), 64'd2);
    proc_cmd = 4'd0;
    step();

    // Reset in the middle of REQ with a concurrent acknowledge.
    niter = 32'd3;
    pulse_cmd(4'd1);
    serve("rst_a", 64'd11, 64'd121, 0);
    wait_req("rst_b");
    dp_ack = 1'b1; dp_val = 64'd50; dp_sq = 64'd2500;
    nRESET = 1'b0;
    #2;
    check("midrst_dp_req",  64'(dp_req), 64'd0);
    check("midrst_status",  64'(proc_status), 64'd0);
    check("midrst_sum",     proc_sum_dout, 64'd0);
    check("midrst_pow_sum", proc_pow_sum_dout, 64'd0);
    step();
    dp_ack = 1'b0; dp_val = 64'd0; dp_sq = 64'd0;
    nRESET = 1'b1;
    repeat (3) step();
    check("postrst_status", 64'(proc_status), 64'd0);
    check("postrst_dp_req", 64'(dp_req), 64'd0);
    check("postrst_sum",    proc_sum_dout, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
